// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC through instruction memory,
// follows taken branches, stops on HALT and counts retired instructions.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Branch,
    input  logic             Halt,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ImemAddr,
    input  logic [8:0]       ImemData,
    output logic [8:0]       Inst,
    output logic             InstValid,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [8:0]       HALT_OP = 9'h1E0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_inc;

    // Retired-instruction count sticks at its maximum instead of wrapping
    always_comb begin
        count_inc = count;
        if (count != CNT_MAX) begin
            count_inc = count + 1'b1;
        end
    end

    // Next state, PC and count; Start beats Halt, Halt beats Branch
    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = count;
        case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    count_next = '0;
                end
            end
            RUN: begin
                if (Start) begin
                    pc_next    = '0;
                    count_next = '0;
                end else if (Halt) begin
                    state_next = HALTED;
                    count_next = count_inc;
                end else if (Branch) begin
                    pc_next    = Target;
                    count_next = count_inc;
                end else begin
                    pc_next    = pc + 1'b1;
                    count_next = count_inc;
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
                count_next = '0;
            end
        endcase
    end

    // State, PC and count registers; reset takes effect without a clock
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
        end
    end

    // Outputs come from registers; only Inst passes memory data through in RUN
    always_comb begin
        ImemAddr  = pc;
        InstCount = count;
        InstValid = (state == RUN);
        Busy      = (state == RUN);
        Done      = (state == HALTED);
        Inst      = (state == RUN) ? ImemData : HALT_OP;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetches,
// a negedge monitor pops and compares every live instruction.
module tb_fetch_unit;

    localparam int         PC_W    = 10;
    localparam int         CNT_W   = 6;
    localparam logic [8:0] HALT_OP = 9'h1E0;
    localparam logic [8:0] NOP_OP  = 9'h000;

    typedef struct {
        logic [PC_W-1:0]  addr;
        logic [CNT_W-1:0] cnt;
        logic [8:0]       inst;
    } exp_t;

    logic             Clk;
    logic             Reset_n;
    logic             Start;
    logic             Branch;
    logic             Halt;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  ImemAddr;
    logic [8:0]       ImemData;
    logic [8:0]       Inst;
    logic             InstValid;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] InstCount;

    logic [8:0]       imem [0:(1<<PC_W)-1];
    logic [PC_W-1:0]  btab [0:63];
    logic             brk_on_halt;
    exp_t             exp_q[$];
    int               checks;
    int               errors;

    fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Branch    (Branch),
        .Halt      (Halt),
        .Target    (Target),
        .ImemAddr  (ImemAddr),
        .ImemData  (ImemData),
        .Inst      (Inst),
        .InstValid (InstValid),
        .Busy      (Busy),
        .Done      (Done),
        .InstCount (InstCount)
    );

    // Combinational memory and a tiny decoder: 101xxxxxx is a branch via btab
    assign ImemData = imem[ImemAddr];
    assign Halt     = (Inst == HALT_OP);
    assign Branch   = (Inst[8:6] == 3'b101) | (brk_on_halt & Halt);
    assign Target   = (brk_on_halt & Halt) ? 10'h155 : btab[Inst[5:0]];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every live instruction must match the head of the scoreboard
    always @(negedge Clk) begin
        if (Reset_n && InstValid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_fetch", {22'd0, ImemAddr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("fetch_addr", {22'd0, ImemAddr}, {22'd0, e.addr});
                checkOutput("fetch_count", {26'd0, InstCount}, {26'd0, e.cnt});
                checkOutput("fetch_inst", {23'd0, Inst}, {23'd0, e.inst});
                checkOutput("fetch_busy", {31'd0, Busy}, 32'd1);
            end
        end
    end

    task automatic clearMem();
        for (int i = 0; i < (1 << PC_W); i++) imem[i] = NOP_OP;
        for (int i = 0; i < 64; i++) btab[i] = '0;
    endtask

    task automatic pushExp(input int addr, input int cnt);
        exp_t e;
        e.addr = addr[PC_W-1:0];
        e.cnt  = cnt[CNT_W-1:0];
        e.inst = imem[addr];
        exp_q.push_back(e);
    endtask

    task automatic checkIdleOutputs(input string tag, input logic done_req);
        checkOutput({tag, "_addr"}, {22'd0, ImemAddr}, 32'd0);
        checkOutput({tag, "_count"}, {26'd0, InstCount}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, InstValid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, Done}, {31'd0, done_req});
        checkOutput({tag, "_inst"}, {23'd0, Inst}, {23'd0, HALT_OP});
    endtask

    // Launch and expect Done exactly n edges after the launch edge
    task automatic applyStimulus(input int n);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        checkOutput("launch_done", {31'd0, Done}, 32'd0);
        checkOutput("launch_addr", {22'd0, ImemAddr}, 32'd0);
        checkOutput("launch_count", {26'd0, InstCount}, 32'd0);
        repeat (n - 1) @(posedge Clk);
        #1 checkOutput("pre_done", {31'd0, Done}, 32'd0);
        @(posedge Clk);
        #1 checkOutput("done_rise", {31'd0, Done}, 32'd1);
        checkOutput("done_busy", {31'd0, Busy}, 32'd0);
    endtask

    task automatic checkHalted(input int addr, input int cnt);
        checkOutput("halt_addr", {22'd0, ImemAddr}, addr);
        checkOutput("halt_count", {26'd0, InstCount}, cnt);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        brk_on_halt = 1'b0;
        Start       = 1'b0;
        Reset_n     = 1'b0;
        clearMem();
        #2 checkIdleOutputs("reset", 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Straight-line program, HALT at 4, then hold in HALTED
        imem[4] = HALT_OP;
        for (int i = 0; i < 5; i++) pushExp(i, i);
        applyStimulus(5);
        checkHalted(4, 5);
        repeat (3) @(posedge Clk);
        #1 checkHalted(4, 5);
        checkOutput("hold_done", {31'd0, Done}, 32'd1);

        // Relaunch from HALTED; branch at 3 to 0x2A without a bubble
        clearMem();
        imem[3]    = 9'h141;
        btab[1]    = 10'h02A;
        imem[10'h2B] = HALT_OP;
        pushExp(0, 0); pushExp(1, 1); pushExp(2, 2); pushExp(3, 3);
        pushExp(10'h2A, 4); pushExp(10'h2B, 5);
        applyStimulus(6);
        checkHalted(10'h2B, 6);

        // Halt and Branch together: halt wins, Target ignored
        clearMem();
        imem[2]     = HALT_OP;
        brk_on_halt = 1'b1;
        pushExp(0, 0); pushExp(1, 1); pushExp(2, 2);
        applyStimulus(3);
        checkHalted(2, 3);
        brk_on_halt = 1'b0;

        // PC wrap 0x3FF->0, Start restart in RUN, then async reset mid-cycle
        clearMem();
        imem[0] = 9'h142;
        btab[2] = 10'h3FE;
        pushExp(0, 0); pushExp(10'h3FE, 1); pushExp(10'h3FF, 2); pushExp(0, 3);
        pushExp(0, 0); pushExp(10'h3FE, 1);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        checkOutput("restart_addr", {22'd0, ImemAddr}, 32'd0);
        checkOutput("restart_count", {26'd0, InstCount}, 32'd0);
        checkOutput("restart_busy", {31'd0, Busy}, 32'd1);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1 checkIdleOutputs("async_reset", 1'b0);
        #1 Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1 checkIdleOutputs("post_reset_idle", 1'b0);

        // Relaunch after reset counts from zero again
        clearMem();
        imem[4] = HALT_OP;
        for (int i = 0; i < 5; i++) pushExp(i, i);
        applyStimulus(5);
        checkHalted(4, 5);

        // Count saturates at 63 with 71 retired instructions
        clearMem();
        imem[70] = HALT_OP;
        for (int i = 0; i <= 70; i++) pushExp(i, (i > 63) ? 63 : i);
        applyStimulus(71);
        checkHalted(70, 63);

        repeat (2) @(posedge Clk);
        #1 checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
